mult_div_sequencer: RTL and testbench
=====================================

Name: mult_div_sequencer

Overview:
Multi-cycle multiply/divide unit with its sequencing FSM. It executes MULT, MULTU, DIV and DIVU for the multicycle MIPS datapath. The main control FSM issues a one-cycle start pulse and holds in a wait state until done. Results land in architectural HI/LO registers, which later feed MFHI/MFLO through the register-write mux.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request, sampled only in IDLE
op  input  2  operation, sampled with start: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU
a_in  input  WIDTH  operand rs (A register output)
b_in  input  WIDTH  operand rt (B register output)
mt_hi  input  1  MTHI write strobe, honoured only in IDLE
mt_lo  input  1  MTLO write strobe, honoured only in IDLE
mt_data  input  WIDTH  data for MTHI/MTLO
busy  output  1  high in CALC and FIX
done  output  1  one-cycle pulse, high in DONE
div_zero  output  1  sticky until next accepted start; set by DIV/DIVU with b_in=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high. It has priority over everything, including mid-operation: FSM goes to IDLE, and hi, lo, div_zero, busy, done all become 0, with the counter and working registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge 0:
  - Latch op.
  - Latch |a| and |b| for signed ops (raw values for unsigned ops).
  - Latch the sign bits; clear div_zero; counter := 0; go to CALC.
- Divide-by-zero exception to the above: DIV/DIVU with b_in=0 goes directly to DONE with div_zero=1 and hi/lo unchanged. done is high in cycle 1.
- CALC: one iteration per cycle, WIDTH cycles (edges 1..32).
  - Multiply: radix-2 shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division (shift remainder left, trial subtract, quotient bit = no-borrow).
  - After the edge where counter=WIDTH-1, go to FIX.
- FIX (edge 33):
  - Apply sign correction and write hi/lo, then go to DONE.
  - MULT: negate the 64-bit product if sign(a)^sign(b); hi=product[63:32], lo=product[31:0].
  - DIV: lo=quotient, negated if sign(a)^sign(b); hi=remainder, negated if sign(a) (remainder takes the dividend's sign).
  - Unsigned ops: no correction.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE (edge 34).
- Latency: start sampled at edge 0 gives done high during cycle 34. busy is high in cycles 1–33.
- start outside IDLE is ignored, with no queueing.
- mt_hi/mt_lo are honoured only in IDLE when start=0. If start=1 in the same cycle, start wins and mt strobes are dropped. Strobes outside IDLE are dropped.
- hi/lo change only at: reset, FIX, or mt writes.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
- All arithmetic is modulo 2^WIDTH (or 2^(2*WIDTH) for the product). Absolute value of 0x80000000 is treated as unsigned 0x80000000.

Decomposition:
- Package mdu_pkg: mdu_op_t enum (MULT, MULTU, DIV, DIVU); mdu_state_t enum (IDLE, CALC, FIX, DONE); localparam MDU_ITER=32.
- One sub-module, mdu_step: combinational single-iteration datapath. Inputs: op class, accumulator/remainder, multiplicand/divisor. Output: next accumulator/remainder and quotient bit.
- The FSM, counter, sign latches and HI/LO stay in mult_div_sequencer.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7, start at cycle 0 -> busy cycles 1–33, done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIVU a=7, b=2 -> lo=3, hi=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=5, b=0 with prior hi=0x11, lo=0x22 -> done in cycle 1, div_zero=1, hi=0x11, lo=0x22 unchanged. Next accepted start clears div_zero.
- MULT started, Reset=1 in cycle 10 -> cycle 11: busy=0, hi=lo=0, no done pulse. A start in cycle 11 is accepted normally.
- start pulsed in cycle 5 of a running op and mt_hi=1 with mt_data=0xABCD in cycle 5 -> both ignored, result unaffected. mt_hi in IDLE -> hi=0xABCD next cycle. start+mt_lo in the same IDLE cycle -> start accepted, lo not written by mt.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit.
// Op encoding and FSM states used by the sequencer and step datapath.
package mdu_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  function automatic logic op_is_div(mdu_op_t o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(mdu_op_t o);
    return !o[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide.
// The quotient bit is returned separately; the caller inserts it.
import mdu_pkg::*;

module mdu_step #(
  parameter int WIDTH = MDU_ITER
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               q_bit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
          + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shl   = acc[2*WIDTH-1:WIDTH-1];
    // remainder after a successful subtract always fits in WIDTH bits
    diff  = shl[WIDTH-1:0] - opnd;
    q_bit = 1'b0;
    if (is_div) begin
      q_bit   = (shl >= {1'b0, opnd});
      acc_nxt = {q_bit ? diff : shl[WIDTH-1:0],
                 acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Operates on magnitudes; signs are reapplied in FIX.
import mdu_pkg::*;

module mult_div_sequencer #(
  parameter int WIDTH = MDU_ITER
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  mdu_state_t       state, nxt;
  mdu_op_t          op_q, op_c;
  logic [CW-1:0]    cnt;
  logic             sa_q, sb_q;
  logic [2*WIDTH-1:0] acc_q, step_acc;
  logic [WIDTH-1:0] opnd_q;
  logic             step_q;

  logic             a_neg, b_neg, div0;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_is_div(op_q)),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .acc_nxt (step_acc),
    .q_bit   (step_q)
  );

  always_comb begin
    op_c  = mdu_op_t'(op);
    a_neg = op_is_signed(op_c) & a_in[WIDTH-1];
    b_neg = op_is_signed(op_c) & b_in[WIDTH-1];
    mag_a = a_neg ? -a_in : a_in;
    mag_b = b_neg ? -b_in : b_in;
    div0  = op_is_div(op_c) && (b_in == '0);
    prod  = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo   = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem   = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    nxt  = state;
    busy = (state == CALC) || (state == FIX);
    done = (state == DONE);
    unique case (state)
      IDLE:    if (start) nxt = div0 ? DONE : CALC;
      CALC:    if (cnt == LAST) nxt = FIX;
      FIX:     nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      op_q     <= MULT;
      cnt      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op_c;
            sa_q     <= a_neg;
            sb_q     <= b_neg;
            acc_q    <= {{WIDTH{1'b0}}, mag_a};
            opnd_q   <= mag_b;
            cnt      <= '0;
            div_zero <= div0;
          end else begin
            if (mt_hi) hi <= mt_data;
            if (mt_lo) lo <= mt_data;
          end
        end
        CALC: begin
          acc_q <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
          cnt   <= cnt + 1'b1;
        end
        FIX: begin
          if (op_is_div(op_q)) begin
            hi <= op_is_signed(op_q) ? rem : acc_q[2*WIDTH-1:WIDTH];
            lo <= op_is_signed(op_q) ? quo : acc_q[WIDTH-1:0];
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer.
// Reference results come from 64-bit integer arithmetic.
module tb_mult_div_sequencer;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset, start, mt_hi, mt_lo;
  logic [1:0]   op;
  logic [W-1:0] a_in, b_in, mt_data;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  mult_div_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .mt_hi(mt_hi), .mt_lo(mt_lo),
    .mt_data(mt_data), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } res_t;

  res_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic res_t model(logic [1:0] o, logic [31:0] a,
                                 logic [31:0] b);
    res_t   r;
    longint x, y, p, q, rm;
    r.hi = m_hi;
    r.lo = m_lo;
    r.dz = 1'b0;
    if (o[0]) begin
      x = longint'({32'b0, a});
      y = longint'({32'b0, b});
    end else begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end
    if (!o[1]) begin
      p = x * y;
      {r.hi, r.lo} = p;
    end else if (b == 32'd0) begin
      r.dz = 1'b1;
    end else begin
      q  = x / y;
      rm = x % y;
      r.lo = q[31:0];
      r.hi = rm[31:0];
    end
    return r;
  endfunction

  task automatic drive_start(input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, output bit d0);
    res_t r;
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    r = model(o, a, b);
    exp_q.push_back(r);
    m_hi = r.hi;
    m_lo = r.lo;
    d0 = r.dz;
  endtask

  task automatic finish_op(input bit d0, input bit inj);
    int bc = 0;
    int dc = 0;
    @(posedge Clk); #1;
    start = 1'b0;
    mt_hi = 1'b0;
    mt_lo = 1'b0;
    for (int c = 1; c <= 60 && dc == 0; c++) begin
      if (inj && c == 5) begin
        start   = 1'b1;
        mt_hi   = 1'b1;
        mt_data = 32'h0000ABCD;
        op      = 2'($urandom_range(0, 3));
        a_in    = $urandom;
        b_in    = '0;
      end else if (inj && c == 6) begin
        start = 1'b0;
        mt_hi = 1'b0;
      end
      @(negedge Clk);
      if (busy) bc++;
      if (done) dc = c;
      if (dc == 0) begin
        @(posedge Clk); #1;
      end
    end
    chk("done_cycle", 80'(dc), d0 ? 80'd1 : 80'd34);
    chk("busy_cycles", 80'(bc), d0 ? 80'd0 : 80'd33);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit inj);
    bit d0;
    @(posedge Clk); #1;
    drive_start(o, a, b, d0);
    finish_op(d0, inj);
  endtask

  always @(negedge Clk) begin
    res_t e;
    if (!Reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 80'(exp_q.size()), 80'd1);
      end else begin
        e = exp_q.pop_front();
        chk("result", {15'd0, hi, lo, div_zero}, {15'd0, e});
      end
    end
  end

  initial begin
    bit          d0;
    int          sel;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    Reset = 1'b1; start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
    op = '0; a_in = '0; b_in = '0; mt_data = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset_state", {13'd0, busy, done, div_zero, hi, lo}, 80'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    issue(2'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    issue(2'd3, 32'd7, 32'd2, 1'b0);
    issue(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);

    @(posedge Clk); #1;
    mt_hi = 1'b1; mt_data = 32'h11;
    @(posedge Clk); #1;
    mt_hi = 1'b0; mt_lo = 1'b1; mt_data = 32'h22; m_hi = 32'h11;
    @(posedge Clk); #1;
    mt_lo = 1'b0; m_lo = 32'h22;
    @(negedge Clk);
    chk("mt_write", {16'd0, hi, lo}, {16'd0, 32'h11, 32'h22});

    @(posedge Clk); #1;
    drive_start(2'd2, 32'd5, 32'd0, d0);
    mt_lo = 1'b1; mt_data = 32'h99;
    finish_op(d0, 1'b0);
    @(negedge Clk);
    chk("div_zero_sticky", 80'(div_zero), 80'd1);
    issue(2'd1, 32'd3, 32'd5, 1'b0);

    issue(2'd0, $urandom, $urandom, 1'b1);

    @(posedge Clk); #1;
    mt_hi = 1'b1; mt_data = 32'h0000ABCD;
    @(posedge Clk); #1;
    mt_hi = 1'b0; m_hi = 32'h0000ABCD;
    @(negedge Clk);
    chk("mt_hi_idle", 80'(hi), 80'h0000ABCD);

    @(posedge Clk); #1;
    start = 1'b1; op = 2'd0; a_in = $urandom; b_in = $urandom;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (9) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0; m_hi = '0; m_lo = '0;
    drive_start(2'd0, 32'd3, 32'hFFFFFFFC, d0);
    @(negedge Clk);
    chk("after_reset", {14'd0, busy, done, hi, lo}, 80'd0);
    finish_op(d0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) rb = '0;
      if (sel == 1) rb = '1;
      if (sel == 2) ra = 32'h80000000;
      if (sel == 3) rb = 32'($urandom_range(1, 20));
      issue(ro, ra, rb, 1'b0);
    end

    repeat (3) @(posedge Clk);
    chk("queue_empty", 80'(exp_q.size()), 80'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
